// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared imem geometry, word layout and loader state encoding
package imem_pkg;

  localparam int IMEM_ADDR_W    = 7;
  localparam int IMEM_DEPTH     = 128;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } loader_state_e;

  // Little-endian byte lane select: lane 0 is bits 7:0.
  function automatic logic [7:0] word_byte(input logic [31:0] w,
                                           input logic [BYTE_IDX_W-1:0] idx);
    return w[8*idx +: 8];
  endfunction

endpackage

// File: rtl/imem_word_serializer.sv
// rtl/imem_word_serializer.sv - holds one 32-bit word and presents it one byte per cycle
module imem_word_serializer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        last_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        last_byte_o,
  output logic        word_last_o,
  output logic        can_load_o
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [31:0]           hold_q, hold_d;
  logic                  hold_v_q, hold_v_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic                  last_q, last_d;

  // Capture a new word, otherwise step through its bytes and drain after the top lane.
  always_comb begin
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    idx_d    = idx_q;
    last_d   = last_q;
    if (load_i) begin
      hold_d   = word_i;
      hold_v_d = 1'b1;
      idx_d    = '0;
      last_d   = last_i;
    end else if (hold_v_q) begin
      if (idx_q == LAST_IDX) begin
        hold_v_d = 1'b0;
        idx_d    = '0;
        last_d   = 1'b0;
      end else begin
        idx_d = idx_q + BYTE_IDX_W'(1);
      end
    end
  end

  // Holding register and byte index; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      idx_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
  end

  assign byte_o      = word_byte(hold_q, idx_q);
  assign valid_o     = hold_v_q;
  assign last_byte_o = (idx_q == LAST_IDX);
  assign word_last_o = last_q;
  // A new word may land on the same edge the top lane is written.
  assign can_load_o  = !hold_v_q || (idx_q == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams 32-bit words into the byte imem; optional IMEM_LOADER_CHECKSUM_EN
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int DEPTH     = IMEM_DEPTH,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              w_en_imem,
  output logic [ADDR_W-1:0] w_addr_imem,
  output logic [7:0]        w_data_imem,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   bytes_loaded
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + DEPTH - 1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [7:0] ser_byte;
  logic       ser_valid, ser_last_byte, ser_word_last, ser_can_load;
  logic       accept, start_ok, word_end, ovf_pending;

  imem_word_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .word_i      (s_data),
    .last_i      (s_last),
    .byte_o      (ser_byte),
    .valid_o     (ser_valid),
    .last_byte_o (ser_last_byte),
    .word_last_o (ser_word_last),
    .can_load_o  (ser_can_load)
  );

  // Next state, counters and handshake; the top byte at LAST_ADDR of a non-last word ends the load.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    err_d       = err_q;
    start_ok    = start && (state_q != LD_LOAD);
    word_end    = ser_valid && ser_last_byte;
    ovf_pending = word_end && !ser_word_last && (addr_q == LAST_ADDR);
    s_ready     = (state_q == LD_LOAD) && ser_can_load && !ser_word_last && !ovf_pending;
    accept      = s_valid && s_ready;
    case (state_q)
      LD_IDLE, LD_DONE: begin
        if (start) begin
          state_d = LD_LOAD;
          addr_d  = BASE;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LD_LOAD: begin
        if (ser_valid) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q + (ADDR_W+1)'(1);
        end
        if (word_end && ser_word_last) begin
          state_d = LD_DONE;
          done_d  = 1'b1;
        end else if (ovf_pending) begin
          state_d = LD_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // State, address and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign w_en_imem    = ser_valid;
  assign w_addr_imem  = addr_q;
  assign w_data_imem  = ser_byte;
  assign busy         = (state_q == LD_LOAD);
  assign done         = done_q;
  assign err          = err_q;
  assign bytes_loaded = cnt_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] cks_q, cks_d;

  // Wrapping sum of every accepted word, restarted with each load.
  always_comb begin
    cks_d = cks_q;
    if (start_ok) begin
      cks_d = '0;
    end else if (accept) begin
      cks_d = cks_q + s_data;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cks_q <= '0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign checksum = cks_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_last;
  logic [31:0] s_data;
  logic        s_ready, w_en_imem, busy, done, err;
  logic [6:0]  w_addr_imem;
  logic [7:0]  w_data_imem;
  logic [7:0]  bytes_loaded;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int errors = 0;
  logic [14:0] wlog[$];

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .w_en_imem    (w_en_imem),
    .w_addr_imem  (w_addr_imem),
    .w_data_imem  (w_data_imem),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .bytes_loaded (bytes_loaded)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Memory-side view: every byte write, as {addr, data}, in order.
  always @(negedge clk) begin
    if (w_en_imem) wlog.push_back({w_addr_imem, w_data_imem});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        start, v;
    logic [31:0] d;
    logic        last;
    logic        rdy, wen;
    logic [6:0]  addr;
    logic [7:0]  wd;
    logic        busy, done;
  } cyc_vec_t;

  typedef struct {
    int n;
    bit last;
    int gmin, gmax;
    int fixed;
    int start_at;
    int exp_bytes;
    bit exp_err;
  } load_vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_s_ready"}, s_ready, 0);
    check({p, "_w_en"}, w_en_imem, 0);
    check({p, "_w_addr"}, w_addr_imem, 0);
    check({p, "_w_data"}, w_data_imem, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_err"}, err, 0);
    check({p, "_bytes"}, bytes_loaded, 0);
  endtask

  // Drive one load and compare against the expected image: word k byte j lands at 4k+j.
  task automatic run_load(input int r, input load_vec_t v);
    logic [31:0] w[$];
    logic [31:0] tmp, sum;
    logic [7:0]  eb;
    int i, cyc, gap, acc_exp, nlog;
    bit hs;
    for (int k = 0; k < v.n; k++) begin
      if (v.fixed == 1)      w.push_back(k == 0 ? 32'h00500093 : 32'h00A00113);
      else if (v.fixed == 2) w.push_back(k == 0 ? 32'hFFFFFFFF : 32'h00000002);
      else                   w.push_back($urandom);
    end
    wlog.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    check($sformatf("L%0d_start_done", r), done, 0);
    check($sformatf("L%0d_start_err", r), err, 0);
    check($sformatf("L%0d_start_busy", r), busy, 1);
    check($sformatf("L%0d_start_bytes", r), bytes_loaded, 0);
    i = 0; cyc = 0; gap = 0;
    while (!done && cyc < 2000) begin
      start = (cyc == v.start_at);
      if (gap > 0) begin
        s_valid = 1'b0; s_last = 1'b0; gap--;
      end else if (i < v.n) begin
        s_valid = 1'b1; s_data = w[i]; s_last = v.last && (i == v.n - 1);
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      hs = s_valid && s_ready;
      step();
      if (hs) begin
        i++;
        gap = $urandom_range(v.gmax, v.gmin);
      end
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    acc_exp = v.exp_bytes / 4;
    check($sformatf("L%0d_done", r), done, 1);
    check($sformatf("L%0d_accepted", r), i, acc_exp);
    check($sformatf("L%0d_err", r), err, v.exp_err);
    check($sformatf("L%0d_bytes", r), bytes_loaded, v.exp_bytes);
    check($sformatf("L%0d_busy", r), busy, 0);
    check($sformatf("L%0d_ready", r), s_ready, 0);
    repeat (3) step();
    nlog = wlog.size();
    check($sformatf("L%0d_nwrites", r), nlog, v.exp_bytes);
    for (int k = 0; k < nlog && k < v.exp_bytes; k++) begin
      tmp = w[k / 4];
      eb  = tmp[8 * (k % 4) +: 8];
      check($sformatf("L%0d_wr%0d", r, k), wlog[k], {7'(k), eb});
    end
    sum = '0;
    for (int k = 0; k < acc_exp; k++) sum += w[k];
`ifdef IMEM_LOADER_CHECKSUM_EN
    check($sformatf("L%0d_checksum", r), checksum, sum);
`endif
  endtask

  cyc_vec_t  cv[11];
  load_vec_t lv[8];
  load_vec_t rv;
  int hs_n, cyc, n0;
  bit h;

  initial begin
    cv[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0};
    cv[1]  = '{1'b0, 1'b1, 32'h00500093, 1'b0, 1'b1, 1'b0, 7'd0, 8'h00, 1'b1, 1'b0};
    cv[2]  = '{1'b0, 1'b1, 32'h00A00113, 1'b1, 1'b0, 1'b1, 7'd0, 8'h93, 1'b1, 1'b0};
    cv[3]  = '{1'b0, 1'b1, 32'h00A00113, 1'b1, 1'b0, 1'b1, 7'd1, 8'h00, 1'b1, 1'b0};
    cv[4]  = '{1'b0, 1'b1, 32'h00A00113, 1'b1, 1'b0, 1'b1, 7'd2, 8'h50, 1'b1, 1'b0};
    cv[5]  = '{1'b0, 1'b1, 32'h00A00113, 1'b1, 1'b1, 1'b1, 7'd3, 8'h00, 1'b1, 1'b0};
    cv[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 7'd4, 8'h13, 1'b1, 1'b0};
    cv[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 7'd5, 8'h01, 1'b1, 1'b0};
    cv[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 7'd6, 8'hA0, 1'b1, 1'b0};
    cv[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 7'd7, 8'h00, 1'b1, 1'b0};
    cv[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b1};

    //          n  last gmin gmax fixed start_at bytes err
    lv[0] = '{ 2, 1'b1, 0, 0, 1, -1,   8, 1'b0};
    lv[1] = '{ 2, 1'b1, 6, 6, 1, -1,   8, 1'b0};
    lv[2] = '{32, 1'b1, 0, 0, 0, -1, 128, 1'b0};
    lv[3] = '{33, 1'b0, 0, 0, 0, -1, 128, 1'b1};
    lv[4] = '{40, 1'b0, 0, 3, 0, -1, 128, 1'b1};
    lv[5] = '{ 1, 1'b1, 0, 0, 0, -1,   4, 1'b0};
    lv[6] = '{ 5, 1'b1, 0, 2, 0,  3,  20, 1'b0};
    lv[7] = '{ 3, 1'b1, 1, 1, 0, -1,  12, 1'b0};

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) step();
    check_zero("reset_held");
    rst = 1'b0;
    step();
    check_zero("reset_idle");

    // Two-word load, cycle by cycle, from IDLE.
    for (int k = 0; k < 11; k++) begin
      start = cv[k].start; s_valid = cv[k].v; s_data = cv[k].d; s_last = cv[k].last;
      #1;
      check($sformatf("cyc%0d_ready", k), s_ready, cv[k].rdy);
      check($sformatf("cyc%0d_wen", k), w_en_imem, cv[k].wen);
      check($sformatf("cyc%0d_busy", k), busy, cv[k].busy);
      check($sformatf("cyc%0d_done", k), done, cv[k].done);
      if (cv[k].wen) begin
        check($sformatf("cyc%0d_addr", k), w_addr_imem, cv[k].addr);
        check($sformatf("cyc%0d_data", k), w_data_imem, cv[k].wd);
      end
      step();
    end
    start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    check("cyc_end_done", done, 1);
    check("cyc_end_err", err, 0);
    check("cyc_end_bytes", bytes_loaded, 8);

    for (int r = 0; r < 8; r++) run_load(r, lv[r]);

    // Reset while the second byte of the third word is on the write port.
    start = 1'b1;
    step();
    start = 1'b0;
    hs_n = 0; cyc = 0;
    while (hs_n < 3 && cyc < 100) begin
      s_valid = 1'b1; s_data = $urandom; s_last = 1'b0;
      h = s_ready;
      step();
      if (h) hs_n++;
      cyc++;
    end
    check("rst_seq_words", hs_n, 3);
    step();
    check("rst_seq_wen", w_en_imem, 1);
    check("rst_seq_addr", w_addr_imem, 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_zero("rst_seq_after");
    n0 = wlog.size();
    repeat (5) step();
    check("rst_seq_no_writes", wlog.size(), n0);
    check("rst_seq_ready", s_ready, 0);
    s_valid = 1'b0;
    run_load(8, lv[0]);

    for (int r = 9; r < 15; r++) begin
      rv.n = $urandom_range(32, 1);
      rv.last = 1'b1; rv.gmin = 0; rv.gmax = 4; rv.fixed = 0; rv.start_at = -1;
      rv.exp_bytes = 4 * rv.n; rv.exp_err = 1'b0;
      run_load(r, rv);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    rv = '{2, 1'b1, 0, 0, 2, -1, 8, 1'b0};
    run_load(15, rv);
    check("checksum_wrap", checksum, 32'h00000001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the byte-addressed, little-endian, combinational-read instruction memory (128 x 8-bit, 7-bit byte address).
- Accepts 32-bit program words over a valid/ready stream and serialises each word into four byte writes on the imem write port: byte 0 (bits 7:0) at the lowest address.
- Used at boot or by the test harness to load a program before the core is released from reset.
- Asserts `done` when the stream ends, or `err` when the memory would overflow.

Parameters:
- ADDR_W, 7: imem byte-address width.
- DEPTH, 128: imem size in bytes; must be a multiple of 4 and ≤ 2^ADDR_W.
- BASE_ADDR, 0: first byte address written; must be word-aligned.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless in IDLE or DONE.
- s_valid  in  1  input word valid.
- s_data  in  32  program word.
- s_last  in  1  marks the final word of the program; qualified by s_valid.
- s_ready  out  1  loader can accept a word this cycle.
- w_en_imem  out  1  byte write strobe.
- w_addr_imem  out  ADDR_W  byte write address.
- w_data_imem  out  8  byte write data.
- busy  out  1  high in LOAD.
- done  out  1  sticky; load finished.
- err  out  1  sticky; overflow, load aborted.
- bytes_loaded  out  ADDR_W+1  count of bytes written since start.

Behaviour:
- Reset, applied synchronously while rst is high:
  - State goes to IDLE.
  - All outputs are 0; the holding register, address counter and byte index are cleared.
  - Memory contents are not touched.
  - Reset during LOAD discards the partial word. Bytes already written remain in memory.
- State machine has three states: IDLE, LOAD, DONE.
  - IDLE → LOAD on start. On entry, load the address to BASE_ADDR and clear bytes_loaded, done and err.
  - LOAD → DONE after the final byte of a word accepted with s_last=1, or on overflow.
  - DONE → LOAD on start, with the same initialisation as from IDLE. Otherwise DONE holds.
- Handshake:
  - A word transfers when s_valid && s_ready.
  - s_ready = (state==LOAD) && (!hold_v || byte_idx==3) && !last_q && !ovf_pending.
  - Back-to-back words give a sustained throughput of 1 word per 4 cycles.
- Latency:
  - For a word accepted at edge t, its bytes 0..3 are driven with w_en_imem=1 in cycles t+1..t+4.
  - Addresses are A, A+1, A+2, A+3, with w_data_imem = s_data[8k+7:8k].
- Write strobe:
  - w_en_imem is high only while a byte is pending.
  - Outputs are registered; there is no combinational path from s_* to w_*.
- Counters: the address increments by 1 per byte written; bytes_loaded increments with it.
- Completion: `done` rises in the cycle after the 4th byte of the last word is written. busy falls in the same cycle.
- Overflow:
  - When the byte at BASE_ADDR+DEPTH-1 is written and that word was not last, the loader does not wrap.
  - s_ready stays low, state goes to DONE, and done=1, err=1 in the following cycle.
  - A last word ending exactly at DEPTH-1 is a normal completion with err=0.
- Simultaneous events:
  - rst has priority over everything.
  - A start received in LOAD is ignored.
  - Words offered in IDLE or DONE are not accepted; s_ready is 0.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN
  - When defined: adds output checksum [31:0], cleared on reset and on start. It is the wrapping 32-bit sum of every accepted s_data, updated on each handshake and final when done rises.
  - When undefined: the port and adder are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package imem_pkg holds:
  - IMEM_ADDR_W=7 and IMEM_DEPTH=128.
  - Loader state encoding: IDLE=2'd0, LOAD=2'd1, DONE=2'd2.
  - BYTES_PER_WORD=4.
- One natural sub-module, imem_word_serializer: the holding register plus byte index, producing byte, valid and last-byte signals. The FSM and counters stay in imem_loader.

Test Plan:
- Reset, start, then words 0x00500093 and 0x00A00113 (last) sent back-to-back → bytes at 0..7 are 93 00 50 00 13 01 A0 00. s_ready is high at cycles 1 and 5. done=1, err=0, bytes_loaded=8.
- Stall the source with gaps of 3 idle cycles between words → no writes during gaps, addresses stay contiguous, same final image.
- Send 32 words with the last flag on word 32 (BASE_ADDR=0) → address reaches 127, done=1, err=0. Send 33 words with no last → after writing byte 127, err=1, done=1, and the 33rd word is never accepted.
- Assert rst during the 2nd byte of the 3rd word → all outputs 0 next cycle and no further writes. A new start reloads from address 0.
- Pulse start while busy → ignored, and the load completes normally. Pulse start in DONE → second load begins at BASE_ADDR and done clears.
- With IMEM_LOADER_CHECKSUM_EN, send words 0xFFFFFFFF and 0x00000002 (last) → checksum=0x00000001 at done.
